// File: rtl/relu_layer_sequencer.sv
`timescale 1ns/1ps
// relu_layer_sequencer
// Accepts one CHANNELS-wide activation vector, rectifies it LANES channels per
// cycle through a small pool of shared ReLU lanes, then offers the assembled
// result downstream. in_ready is the only combinational input-to-output path.
module relu_layer_sequencer #(
  parameter int I_WIDTH  = 8,
  parameter int CHANNELS = 8,
  parameter int LANES    = 2,
  localparam int BEATS   = (LANES > 0) ? (CHANNELS / LANES) : 1,
  localparam int CNT_W   = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [I_WIDTH*CHANNELS-1:0] in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [I_WIDTH*CHANNELS-1:0] out_data,
  output logic                        busy,
  output logic [CNT_W-1:0]            beat
);

  localparam int SLICE_W = LANES * I_WIDTH;
  localparam int VEC_W   = I_WIDTH * CHANNELS;

  generate
    if ((LANES < 1) || (I_WIDTH < 2) || ((CHANNELS % LANES) != 0)) begin : g_param_err
      $error("relu_layer_sequencer: need LANES>=1, I_WIDTH>=2 and CHANNELS divisible by LANES");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t             state_r;
  logic [CNT_W-1:0]   beat_r;
  logic [VEC_W-1:0]   latch_r;
  logic [VEC_W-1:0]   result_r;
  logic               out_valid_r;
  logic               busy_r;
  logic [SLICE_W-1:0] lane_in_s;
  logic [SLICE_W-1:0] lane_out_s;

  // Rectify one channel: negative values clamp to zero, others pass unchanged.
  function automatic logic [I_WIDTH-1:0] relu_fn(input logic [I_WIDTH-1:0] v);
    logic [I_WIDTH-1:0] r;
    if (v[I_WIDTH-1]) begin
      r = {I_WIDTH{1'b0}};
    end else begin
      r = v;
    end
    return r;
  endfunction

  // Pick the group of channels handled by the lanes during the current beat.
  always_comb begin
    lane_in_s = {SLICE_W{1'b0}};
    for (int b = 0; b < BEATS; b++) begin
      if (beat_r == CNT_W'(b)) begin
        lane_in_s = latch_r[b*SLICE_W +: SLICE_W];
      end else begin
        lane_in_s = lane_in_s;
      end
    end
  end

  // Shared ReLU lanes.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign lane_out_s[l*I_WIDTH +: I_WIDTH] = relu_fn(lane_in_s[l*I_WIDTH +: I_WIDTH]);
  end

  // Sequencer: accept, rectify beat by beat, hold the result until taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= S_IDLE;
      beat_r      <= {CNT_W{1'b0}};
      latch_r     <= {VEC_W{1'b0}};
      result_r    <= {VEC_W{1'b0}};
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (in_valid) begin
            latch_r <= in_data;
            beat_r  <= {CNT_W{1'b0}};
            busy_r  <= 1'b1;
            state_r <= S_RUN;
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_RUN: begin
          for (int b = 0; b < BEATS; b++) begin
            if (beat_r == CNT_W'(b)) begin
              result_r[b*SLICE_W +: SLICE_W] <= lane_out_s;
            end
          end
          if (beat_r == CNT_W'(BEATS - 1)) begin
            beat_r      <= {CNT_W{1'b0}};
            out_valid_r <= 1'b1;
            state_r     <= S_HOLD;
          end else begin
            beat_r      <= beat_r + CNT_W'(1);
          end
        end
        S_HOLD: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            if (in_valid) begin
              // Downstream takes the result while a new vector is accepted.
              latch_r <= in_data;
              beat_r  <= {CNT_W{1'b0}};
              state_r <= S_RUN;
            end else begin
              busy_r  <= 1'b0;
              state_r <= S_IDLE;
            end
          end else begin
            state_r <= S_HOLD;
          end
        end
        default: begin
          state_r     <= S_IDLE;
          beat_r      <= {CNT_W{1'b0}};
          out_valid_r <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = (state_r == S_IDLE) | ((state_r == S_HOLD) & out_ready);
  assign out_valid = out_valid_r;
  assign out_data  = result_r;
  assign busy      = busy_r;
  assign beat      = beat_r;

endmodule

// File: tb/tb_relu_layer_sequencer.sv
`timescale 1ns/1ps
// Testbench for relu_layer_sequencer: three instances (LANES = 2, 4, 1) with
// CHANNELS=4, I_WIDTH=8, driven by a vector table, hand-written corner
// sequences and random vectors checked against a channel-wise ReLU model.
module tb_relu_layer_sequencer;

  logic        clk;
  logic        rst_n;
  logic        in_valid  [3];
  logic [31:0] in_data   [3];
  logic        out_ready [3];
  logic        in_ready  [3];
  logic        out_valid [3];
  logic [31:0] out_data  [3];
  logic        busy      [3];
  logic [1:0]  beat      [3];

  int n_tests = 0;
  int n_fail  = 0;

  for (genvar k = 0; k < 3; k++) begin : g_dut
    localparam int L  = (k == 0) ? 2 : ((k == 1) ? 4 : 1);
    localparam int CW = ((4 / L) > 1) ? $clog2(4 / L) : 1;
    logic [CW-1:0] beat_s;
    relu_layer_sequencer #(.I_WIDTH(8), .CHANNELS(4), .LANES(L)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid[k]), .in_ready(in_ready[k]), .in_data(in_data[k]),
      .out_valid(out_valid[k]), .out_ready(out_ready[k]), .out_data(out_data[k]),
      .busy(busy[k]), .beat(beat_s)
    );
    assign beat[k] = 2'(beat_s);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] vin;
    logic [31:0] vexp;
  } vec_t;

  function automatic int beats_of(input int k);
    return (k == 0) ? 2 : ((k == 1) ? 1 : 4);
  endfunction

  // Channel-wise ReLU on the whole vector.
  function automatic logic [31:0] relu_ref(input logic [31:0] v);
    logic [31:0] r;
    r = v;
    for (int c = 0; c < 4; c++) begin
      if ($signed(v[8*c +: 8]) < 0) r[8*c +: 8] = 8'd0;
    end
    return r;
  endfunction

  function automatic logic [31:0] rand_vec();
    logic [31:0] v;
    v = $urandom;
    if ($urandom_range(3) == 0) begin
      for (int c = 0; c < 4; c++) begin
        case ($urandom_range(3))
          0: v[8*c +: 8] = 8'h80;
          1: v[8*c +: 8] = 8'h7F;
          2: v[8*c +: 8] = 8'h00;
          default: v[8*c +: 8] = 8'hFF;
        endcase
      end
    end
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One full transaction on DUT k from IDLE back to IDLE, out_ready held high.
  // in_data churns every cycle after acceptance.
  task automatic transact(input int k, input logic [31:0] vin, input logic [31:0] vexp,
                          input string tag);
    int n;
    chk({tag, "_idle_ready"}, in_ready[k], 1);
    in_valid[k]  = 1'b1;
    in_data[k]   = vin;
    out_ready[k] = 1'b1;
    @(posedge clk); #1;
    in_valid[k] = 1'b0;
    n = 0;
    while (!out_valid[k] && n < 16) begin
      chk({tag, "_run_busy"}, busy[k], 1);
      chk({tag, "_run_ready"}, in_ready[k], 0);
      chk({tag, "_run_beat"}, beat[k], n);
      in_data[k] = $urandom;
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_valid_seen"}, out_valid[k], 1);
    chk({tag, "_latency"}, n, beats_of(k));
    chk({tag, "_data"}, out_data[k], vexp);
    chk({tag, "_hold_ready"}, in_ready[k], 1);
    @(posedge clk); #1;
    chk({tag, "_after_valid"}, out_valid[k], 0);
    chk({tag, "_after_busy"}, busy[k], 0);
  endtask

  vec_t        tbl [7];
  logic [31:0] q   [$];
  logic [31:0] bv  [3];
  logic [31:0] exp_v;
  logic [31:0] v;
  int          n, idx, nout, last, cyc;
  bit          acc, first;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{32'h807FFF05, 32'h007F0005};
    tbl[1] = '{32'h00000000, 32'h00000000};
    tbl[2] = '{32'hFFFFFFFF, 32'h00000000};
    tbl[3] = '{32'h7F7F7F7F, 32'h7F7F7F7F};
    tbl[4] = '{32'h80808080, 32'h00000000};
    tbl[5] = '{32'h01817EFE, 32'h01007E00};
    tbl[6] = '{32'h129A40C0, 32'h12004000};

    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid[k] = 1'b0; in_data[k] = 32'd0; out_ready[k] = 1'b1;
    end

    // Reset state
    #12;
    chk("rst_out_valid", out_valid[0], 0);
    chk("rst_in_ready", in_ready[0], 1);
    chk("rst_out_data", out_data[0], 32'd0);
    chk("rst_busy", busy[0], 0);
    chk("rst_beat", beat[0], 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Table vectors on LANES=2
    for (int i = 0; i < 7; i++) transact(0, tbl[i].vin, tbl[i].vexp, $sformatf("tbl%0d", i));

    // Backpressure: 5 cycles held in HOLD, then a single transfer
    chk("bp_idle_ready", in_ready[0], 1);
    in_valid[0] = 1'b1; in_data[0] = tbl[6].vin; out_ready[0] = 1'b0;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    n = 0;
    while (!out_valid[0] && n < 16) begin @(posedge clk); #1; n++; end
    chk("bp_latency", n, 2);
    for (int i = 0; i < 5; i++) begin
      in_data[0] = $urandom;
      chk("bp_valid", out_valid[0], 1);
      chk("bp_data", out_data[0], tbl[6].vexp);
      chk("bp_in_ready", in_ready[0], 0);
      @(posedge clk); #1;
    end
    out_ready[0] = 1'b1; #1;
    chk("bp_release_ready", in_ready[0], 1);
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      chk("bp_single_xfer", out_valid[0], 0);
      chk("bp_back_idle", in_ready[0], 1);
      @(posedge clk); #1;
    end

    // Back-to-back: in_valid held, three vectors, one output every 3 cycles
    bv[0] = 32'h11F2803A; bv[1] = 32'hC07F0190; bv[2] = 32'h55AA55AA;
    q.delete(); idx = 0; nout = 0; last = -1; first = 1'b1;
    in_valid[0] = 1'b1; in_data[0] = bv[0]; out_ready[0] = 1'b1;
    for (cyc = 0; cyc < 40 && nout < 3; cyc++) begin
      #1;
      acc = in_valid[0] && in_ready[0];
      if (acc) begin
        if (!first) chk("b2b_ready_in_hold", out_valid[0], 1);
        first = 1'b0;
        q.push_back(relu_ref(in_data[0]));
      end
      @(posedge clk); #1;
      if (acc) begin
        idx++;
        if (idx < 3) in_data[0] = bv[idx];
        else in_valid[0] = 1'b0;
      end
      if (out_valid[0]) begin
        if (q.size() > 0) begin
          exp_v = q.pop_front();
          chk($sformatf("b2b_data%0d", nout), out_data[0], exp_v);
        end else begin
          chk("b2b_unexpected_output", 1, 0);
        end
        if (last >= 0) chk("b2b_interval", cyc - last, 3);
        last = cyc;
        nout++;
      end
    end
    in_valid[0] = 1'b0;
    chk("b2b_count", nout, 3);
    chk("b2b_queue_empty", q.size(), 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("b2b_no_dup", out_valid[0], 0);
    end

    // Reset in the middle of RUN
    in_valid[0] = 1'b1; in_data[0] = 32'h7F017F01; out_ready[0] = 1'b1;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    chk("mid_beat0", beat[0], 0);
    @(posedge clk); #1;
    chk("mid_beat1", beat[0], 1);
    rst_n = 1'b0; #1;
    chk("mid_busy", busy[0], 0);
    chk("mid_valid", out_valid[0], 0);
    chk("mid_beat", beat[0], 0);
    chk("mid_data", out_data[0], 32'd0);
    chk("mid_in_ready", in_ready[0], 1);
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      chk("mid_no_valid", out_valid[0], 0);
      @(posedge clk); #1;
    end
    transact(0, tbl[0].vin, tbl[0].vexp, "post_rst");

    // Random vectors on all three lane counts
    for (int i = 0; i < 200; i++) begin
      v = rand_vec(); transact(0, v, relu_ref(v), "rnd_l2");
    end
    for (int i = 0; i < 1000; i++) begin
      v = rand_vec(); transact(1, v, relu_ref(v), "rnd_l4");
    end
    for (int i = 0; i < 1000; i++) begin
      v = rand_vec(); transact(2, v, relu_ref(v), "rnd_l1");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
